// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer that borrows the shared integer ALU for every add/subtract.
// Latency: result valid 36 cycles after accept. Backpressure: holds the result until resp_ready; req_ready is high only when idle.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [5:0] CNT_LAST = 6'(ITERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        ITER,
        FIX_LO,
        FIX_HI,
        DONE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [5:0]      cnt;
    logic [2:0]      op;
    logic            sa;
    logic            sb;

    logic            is_div;
    logic            sel_lo;
    logic            nlo;
    logic            nhi;
    logic [XLEN-1:0] div_s;
    logic            div_ge;
    logic            mul_c;
    logic            acc_sa;
    logic            acc_sb;

    assign req_ready = (state == IDLE);

    assign is_div = op[2];
    assign sel_lo = (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU);

    // A zero divisor leaves the all-ones quotient un-negated; the remainder keeps the dividend's sign.
    assign nlo = is_div ? ((sa ^ sb) & (opb != '0)) : (sa ^ sb);
    assign nhi = is_div ? sa : (sa ^ sb);

    assign div_s  = {hi[XLEN-2:0], lo[XLEN-1]};
    assign div_ge = hi[XLEN-1] | (div_s >= opb);
    assign mul_c  = (alu_result < hi);

    assign acc_sa = req_a[XLEN-1] &
                    ((req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                     (req_op == OP_DIV)  || (req_op == OP_REM));
    assign acc_sb = req_b[XLEN-1] &
                    ((req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM));

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        case (state)
            ABS_A: begin
                if (sa) begin
                    alu_b  = opa;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a = opa;
                end
            end
            ABS_B: begin
                if (sb) begin
                    alu_b  = opb;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a = opb;
                end
            end
            ITER: begin
                if (is_div) begin
                    alu_a  = div_s;
                    alu_b  = opb;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a = hi;
                    alu_b = lo[0] ? opa : '0;
                end
            end
            FIX_LO: begin
                if (nlo) begin
                    alu_b  = lo;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a = lo;
                end
            end
            FIX_HI: begin
                // Product high word: two's-complement carry from the low word only when it is zero.
                if (nhi && !is_div) begin
                    alu_a = ~hi;
                    alu_b = {{(XLEN-1){1'b0}}, (lo == '0)};
                end else if (nhi) begin
                    alu_b  = hi;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a = hi;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hi         <= '0;
            lo         <= '0;
            opa        <= '0;
            opb        <= '0;
            cnt        <= '0;
            op         <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (kill && (state != IDLE)) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op    <= req_op;
                        opa   <= req_a;
                        opb   <= req_b;
                        sa    <= acc_sa;
                        sb    <= acc_sb;
                        state <= ABS_A;
                    end
                end
                ABS_A: begin
                    opa   <= alu_result;
                    state <= ABS_B;
                end
                ABS_B: begin
                    opb   <= alu_result;
                    hi    <= '0;
                    lo    <= is_div ? opa : alu_result;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    if (is_div) begin
                        hi <= div_ge ? alu_result : div_s;
                        lo <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        hi <= {mul_c, alu_result[XLEN-1:1]};
                        lo <= {alu_result[0], lo[XLEN-1:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX_LO;
                    end
                end
                FIX_LO: begin
                    lo    <= alu_result;
                    state <= FIX_HI;
                end
                FIX_HI: begin
                    hi         <= alu_result;
                    resp_data  <= sel_lo ? lo : alu_result;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M corner cases plus random operands against a 64-bit arithmetic model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        kill;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    // Shared integer ALU stand-in.
    assign alu_result = (alu_op == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return a * b;
            3'd1: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps[63:32];
            end
            3'd2: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return ps[63:32];
            end
            3'd3: begin
                pu = {32'b0, a} * {32'b0, b};
                return pu[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp);
        int w;
        w = 0;
        while (!req_ready && w < 200) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            fail_timeout("issue_ready");
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (push) exp_q.push_back(exp);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        if (exp_q.size() != 0) fail_timeout(name);
    endtask

    // Monitor: every handshaken response is compared against the oldest expected value.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL resp_unexpected: got %h expected none", resp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp", resp_data, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          flag;
        logic [31:0] d0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        rst        = 1'b1;
        kill       = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = 32'h0;
        req_b      = 32'h0;
        resp_ready = 1'b1;
        #12;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_alu_a", alu_a, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Latency and busy-ready on the first multiply.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
        cyc  = 0;
        flag = 1'b0;
        while (!resp_valid && cyc < 100) begin
            if (req_ready) flag = 1'b1;
            tick();
            cyc++;
        end
        if (req_ready) flag = 1'b1;
        check("mul_latency", 32'(cyc), 32'd36);
        check("req_ready_busy", 32'(flag), 32'd0);
        drain("drain_mul");

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2,         1'b1, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF);
        issue(3'd5, 32'd100,       32'd7,         1'b1, 32'd14);
        issue(3'd7, 32'd100,       32'd7,         1'b1, 32'd2);
        issue(3'd4, 32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF);
        issue(3'd6, 32'd5,         32'd0,         1'b1, 32'd5);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
        drain("drain_directed");

        // Result held under backpressure, then back-to-back accept after release.
        resp_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
        cyc = 0;
        while (!resp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!resp_valid) fail_timeout("stall_resp");
        d0   = resp_data;
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!resp_valid || resp_data !== d0) flag = 1'b0;
        end
        check("stall_hold", 32'(flag), 32'd1);
        check("stall_data", d0, 32'd14);
        resp_ready = 1'b1;
        tick();
        check("idle_after_release", 32'(req_ready), 32'd1);
        issue(3'd7, 32'd100, 32'd7, 1'b1, 32'd2);
        check("accept_after_release", 32'(req_ready), 32'd0);
        drain("drain_stall");

        // Kill in ITER with cnt==10.
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_idle", 32'(req_ready), 32'd1);
        check("kill_no_valid", 32'(resp_valid), 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) flag = 1'b1;
            tick();
        end
        check("kill_no_resp", 32'(flag), 32'd0);
        issue(3'd3, 32'd3, 32'd3, 1'b1, 32'd0);
        drain("drain_kill");

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            issue(rop, ra, rb, 1'b1, ref_model(rop, ra, rb));
        end
        drain("drain_random");

        // Asynchronous reset while iterating.
        issue(3'd0, 32'd7, 32'd3, 1'b1, 32'd21);
        drain("drain_pre_rst");
        issue(3'd4, 32'h7654_3210, 32'd9, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst_alu_a", alu_a, 32'h0);
        check("midrst_alu_b", alu_b, 32'h0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_data", resp_data, 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions.
- Has no adder of its own. Every 32-bit add/subtract is issued as an ADD or SUB on the shared integer ALU through the alu_* ports, and the ALU result is consumed in the same cycle.
- Sits beside the execute stage. It receives requests and returns results over valid/ready handshakes.
- Completes every operation in a fixed 36 cycles.

Parameters:
- XLEN, 32, operand width. Only 32 is supported.
- ITERS, 32, number of iteration cycles. Must equal XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- kill  in  1  synchronous abort of the in-flight operation
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  in  32  rs1 operand
- req_b  in  32  rs2 operand
- resp_valid  out  1  result valid
- resp_ready  in  1  result accepted
- resp_data  out  32  result
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  4  ALU op: 0000 ADD, 0001 SUB
- alu_result  in  32  ALU result, combinational from alu_a, alu_b and alu_op

Behaviour:
- States: IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, DONE. Registers: hi, lo, opA, opB, cnt[5:0], op, and flags sa, sb.
- Reset: state IDLE, all registers 0, resp_valid=0, resp_data=0. Reset mid-operation discards the operation.
- req_ready = (state==IDLE). A request is accepted on an edge with req_valid && req_ready: latch op, a and b, go to ABS_A.
- Sign flags at accept:
  - sa = a[31] for MULH, MULHSU, DIV and REM; otherwise 0.
  - sb = b[31] for MULH, DIV and REM; otherwise 0.
- ABS_A: if sa, issue 0 SUB a; else a ADD 0. Store the result in opA.
- ABS_B: same operation on b, stored in opB. Then initialise:
  - Multiply: hi=0, lo=opB.
  - Divide: hi=0, lo=opA.
  - cnt=0.
- ITER, multiply (ITERS cycles):
  - Issue hi ADD (lo[0] ? opA : 0), giving sum=alu_result.
  - carry c = (sum <u hi), computed locally.
  - Update hi={c, sum[31:1]}, lo={sum[0], lo[31:1]}.
- ITER, divide (ITERS cycles):
  - s={hi[30:0], lo[31]}. Issue s SUB opB.
  - ge = hi[31] | (s >=u opB), computed locally.
  - Update hi = ge ? alu_result : s, lo={lo[30:0], ge}.
- cnt increments each ITER cycle. Leave ITER when cnt==ITERS-1.
- Negate flags:
  - Multiply: nlo = nhi = sa^sb.
  - Divide: nlo = (sa^sb) & (opB!=0), nhi = sa.
  - For unsigned ops both flags are 0.
- FIX_LO: if nlo, lo = 0 SUB lo; else lo ADD 0.
- FIX_HI:
  - Multiply with nhi: hi = (~hi) ADD {31'b0, lo==0}.
  - Divide with nhi: hi = 0 SUB hi.
  - Otherwise: hi ADD 0.
- Transition to DONE: resp_data = lo for MUL, DIV and DIVU; hi for the other five ops. resp_valid=1.
- DONE: resp_valid and resp_data are held stable until resp_ready. On the handshake edge, go to IDLE and drop resp_valid. No new request is accepted in the same cycle.
- Latency: accept edge E0 → resp_valid high after edge E36 (1+1+32+1+1 states).
- Divide by zero, as a natural consequence of the algorithm:
  - Quotient = 0xFFFFFFFF.
  - Remainder = dividend.
- Overflow, DIV 0x80000000 / -1:
  - Quotient = 0x80000000, remainder = 0.
- kill=1 in any state other than IDLE: next edge returns to IDLE, resp_valid=0, no response is produced. kill in IDLE has no effect. kill has priority over accept and over DONE.
- In IDLE and DONE, alu_a=0, alu_b=0, alu_op=ADD.

Test Plan:
- MUL 7 × 0xFFFFFFFD → resp_data 0xFFFFFFEB. resp_valid rises exactly 36 cycles after accept. req_ready is low throughout.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU on the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 0xFFFFFFFB / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- Hold resp_ready low for 5 cycles after resp_valid → resp_data stable. Release → IDLE next edge, and a new request is accepted the cycle after.
- Pulse kill at ITER cnt=10 → IDLE next edge, no resp_valid. A following MULHU 3×3 returns 0. Assert rst mid-ITER → all outputs 0 immediately.
